sha256_round_sched: RTL and testbench

//  Sequences one SHA-256 compression (FIPS 180-4) per accepted 512-bit block, one round per clock.

---
 rtl/sha256_round_sched_if.sv | 22 ++
 rtl/sha256_round_sched.sv | 149 ++++++++++++++
 tb/tb_sha256_round_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_sched_if.sv
// Block/digest handshake between the padder, the round scheduler and the digest consumer.
// The master modport is the upstream/consumer side; the slave modport is the scheduler.
interface sha256_round_sched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         abort;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;

  modport master (
    output blk_valid, blk_data, blk_first, abort,
    input  blk_ready, busy, digest_valid, digest
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, abort,
    output blk_ready, busy, digest_valid, digest
  );
endinterface

// File: rtl/sha256_round_sched.sv
// SHA-256 compression sequencer: one round per clock, 66 cycles per block including
// acceptance and the final chaining add.
module sha256_round_sched #(
  parameter logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input logic                  clk,
  input logic                  rst_n,
  sha256_round_sched_if.slave  bus
);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [31:0]  hash_q [8];
  logic [31:0]  hash_d [8];
  logic [31:0]  wv_q [8];   // working variables a..h
  logic [31:0]  wv_d [8];
  logic [31:0]  w_q [16];   // w_q[0] is W[t] during round t
  logic [31:0]  w_d [16];
  logic [255:0] digest_q, digest_d;
  logic         dvalid_q, dvalid_d;

  logic [31:0]  t1, t2, w_new;

  always_comb begin
    t1 = wv_q[7] + big_sigma1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
       + K[rnd_q] + w_q[0];
    t2 = big_sigma0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
    w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    hash_d   = hash_q;
    wv_d     = wv_q;
    w_d      = w_q;
    digest_d = digest_q;
    dvalid_d = 1'b0;
    case (state_q)
      StIdle: begin
        // abort is deliberately not looked at here
        if (bus.blk_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = bus.blk_data[511 - 32*i -: 32];
          if (bus.blk_first) begin
            for (int i = 0; i < 8; i++) hash_d[i] = IV[255 - 32*i -: 32];
          end
          wv_d    = hash_d;
          rnd_d   = 6'd0;
          state_d = StRound;
        end
      end
      StRound: begin
        if (bus.abort) begin
          rnd_d   = 6'd0;
          state_d = StIdle;
        end else begin
          wv_d[0] = t1 + t2;
          wv_d[1] = wv_q[0];
          wv_d[2] = wv_q[1];
          wv_d[3] = wv_q[2];
          wv_d[4] = wv_q[3] + t1;
          wv_d[5] = wv_q[4];
          wv_d[6] = wv_q[5];
          wv_d[7] = wv_q[6];
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
          w_d[15] = w_new;
          rnd_d   = rnd_q + 6'd1;
          if (rnd_q == 6'd63) state_d = StFinal;
        end
      end
      StFinal: begin
        state_d = StIdle;
        if (!bus.abort) begin
          for (int i = 0; i < 8; i++) begin
            hash_d[i] = hash_q[i] + wv_q[i];
            digest_d[255 - 32*i -: 32] = hash_d[i];
          end
          dvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rnd_q    <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        hash_q[i] <= IV[255 - 32*i -: 32];
        wv_q[i]   <= 32'd0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      digest_q <= 256'd0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      hash_q   <= hash_d;
      wv_q     <= wv_d;
      w_q      <= w_d;
      digest_q <= digest_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign bus.blk_ready    = (state_q == StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.digest_valid = dvalid_q;
  assign bus.digest       = digest_q;

endmodule

// File: tb/tb_sha256_round_sched.sv
// Bench for sha256_round_sched: known-answer vectors, abort/reset/back-to-back cases and
// random blocks against a plain array-based SHA-256 compression model.
module tb_sha256_round_sched;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_TWO_0 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO_1 = {480'd0, 32'h000001c0};

  localparam logic [31:0] REF_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk;
  logic rst_n;
  sha256_round_sched_if bus ();

  sha256_round_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] model_h;   // chaining value the next non-first block starts from
  logic [255:0] pend;      // expected digest of the block in flight

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, ch, mj, x1, x2;
    logic [255:0] res;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
      x1 = v[7] + s1 + ch + REF_K[t] + w[t];
      s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      x2 = s0 + mj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic send(input string tag, input logic [511:0] d, input logic f, input logic hold,
                      input logic ab);
    check_eq({tag, "_ready"}, 256'(bus.blk_ready), 256'd1);
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_first = f;
    bus.abort     = ab;
    pend = ref_compress(f ? IV : model_h, d);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    if (!hold) bus.blk_valid = 1'b0;
    check_eq({tag, "_busy"}, 256'(bus.busy), 256'd1);
  endtask

  // Waits for the digest pulse of the block accepted just before, then one more edge.
  task automatic wait_digest(input string tag, input logic [255:0] exp);
    int lat;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.digest_valid) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_latency"}, 256'(lat), 256'd65);
    check_eq({tag, "_digest"}, bus.digest, exp);
    check_eq({tag, "_ready_at_valid"}, 256'(bus.blk_ready), 256'd1);
    model_h = exp;
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse_width"}, 256'(bus.digest_valid), 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 256'(bus.blk_ready), 256'd1);
    check_eq({tag, "_busy"}, 256'(bus.busy), 256'd0);
    check_eq({tag, "_dvalid"}, 256'(bus.digest_valid), 256'd0);
    check_eq({tag, "_digest"}, bus.digest, 256'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_h = IV;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [511:0] rblk;
    logic rfirst, rab;
    rst_n = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_first = 1'b0;
    bus.abort     = 1'b0;
    model_h = IV;
    #2;
    check_reset_outputs("init");
    do_reset();

    // abc, single block
    send("abc", BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_digest("abc", DIG_ABC);

    // Two-block message with blk_valid held across the digest cycle
    send("two0", BLK_TWO_0, 1'b1, 1'b1, 1'b0);
    bus.blk_data  = BLK_TWO_1;
    bus.blk_first = 1'b0;
    wait_digest("two0", pend);
    check_eq("two1_accept_e66", 256'(bus.busy), 256'd1);
    bus.blk_valid = 1'b0;
    pend = ref_compress(model_h, BLK_TWO_1);
    wait_digest("two1", DIG_TWO);

    // Abort at round 30, then abc
    send("abort_run", BLK_TWO_0, 1'b1, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_eq("abort_ready", 256'(bus.blk_ready), 256'd1);
    check_eq("abort_busy", 256'(bus.busy), 256'd0);
    check_eq("abort_digest_held", bus.digest, DIG_TWO);
    pulses = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (bus.digest_valid) pulses++;
    end
    check_eq("abort_no_digest", 256'(pulses), 256'd0);
    send("abc_after_abort", BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_digest("abc_after_abort", DIG_ABC);

    // Asynchronous reset at round 40, then abc again
    send("abc_rst", BLK_ABC, 1'b1, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_h = IV;
    @(posedge clk);
    #1;
    send("abc_rerun", BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_digest("abc_rerun", DIG_ABC);

    // Empty message after abc: IV reload, not chaining
    send("empty", BLK_EMPTY, 1'b1, 1'b0, 1'b0);
    wait_digest("empty", DIG_EMPTY);

    // Non-first block straight after reset chains from IV
    do_reset();
    send("nf_after_reset", BLK_ABC, 1'b0, 1'b0, 1'b0);
    wait_digest("nf_after_reset", DIG_ABC);

    // Random blocks, random first flag, abort pulsed during idle acceptance
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
      rfirst = 1'($urandom_range(0, 1));
      rab    = 1'($urandom_range(0, 1));
      send($sformatf("rnd%0d", k), rblk, rfirst, 1'b0, rab);
      wait_digest($sformatf("rnd%0d", k), pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
